axi_rd_ctrl: RTL

- Sequences the read half (AR/R channels) of the team's 64-bit AXI4 master port.
- Accepts simple burst commands (address, beat count) and issues INCR AR requests.
- Tracks up to `MAX_OUTSTANDING` in-flight bursts and forwards returning R beats to a ready/valid output stream with locally generated burst framing.
- Flags response and `r_last` protocol errors; sits between DMA/test sequencers and the AXI interconnect.

---
 rtl/axi_rd_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/axi_rd_ctrl.sv
// axi_rd_ctrl: AXI4 read-channel sequencer; issues INCR AR bursts, tracks outstanding
// bursts in a length FIFO and frames returning R beats onto a ready/valid stream.
module axi_rd_ctrl #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [31:0] cmd_addr_i,
   input  logic [7:0]  cmd_len_i,
   output logic        ar_valid_o,
   input  logic        ar_ready_i,
   output logic [31:0] ar_addr_o,
   output logic [7:0]  ar_len_o,
   output logic [2:0]  ar_size_o,
   output logic [1:0]  ar_burst_o,
   output logic        ar_id_o,
   output logic        ar_user_o,
   output logic        ar_lock_o,
   output logic [2:0]  ar_prot_o,
   output logic [3:0]  ar_cache_o,
   output logic [3:0]  ar_qos_o,
   input  logic        r_valid_i,
   output logic        r_ready_o,
   input  logic [63:0] r_data_i,
   input  logic [1:0]  r_resp_i,
   input  logic        r_last_i,
   input  logic        r_id_i,
   input  logic        r_user_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] out_data_o,
   output logic        out_last_o,
   output logic [1:0]  err_o,
   input  logic        err_clr_i,
   output logic        busy_o
);
   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t          state_q, state_d;
   logic [31:0]     ar_addr_q, ar_addr_d;
   logic [7:0]      ar_len_q, ar_len_d;
   logic [7:0]      fifo_q [MAX_OUTSTANDING];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      beat_q, beat_d;
   logic [1:0]      err_q, err_d;
   logic            active, cmd_hs, r_hs, push, pop;
   logic            unused;

   assign unused = ^{r_id_i, r_user_i, cmd_addr_i[2:0]};

   assign ar_size_o  = 3'd3;
   assign ar_burst_o = 2'b01;
   assign ar_id_o    = 1'b0;
   assign ar_user_o  = 1'b0;
   assign ar_lock_o  = 1'b0;
   assign ar_prot_o  = 3'd0;
   assign ar_cache_o = 4'd0;
   assign ar_qos_o   = 4'd0;
   assign ar_addr_o  = ar_addr_q;
   assign ar_len_o   = ar_len_q;

   always_ff @(posedge clock_i or negedge reset_ni)
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;

   always_comb state_d = (state_q == IDLE) ? (cmd_hs ? REQ : IDLE) : (ar_ready_i ? IDLE : REQ);

   always_comb begin
      ar_valid_o  = state_q == REQ;
      cmd_ready_o = (state_q == IDLE) && (count_q < CW'(MAX_OUTSTANDING));
   end

   // R path is purely combinational; nothing is accepted unless a burst is tracked
   assign active      = count_q != '0;
   assign out_valid_o = r_valid_i & active;
   assign r_ready_o   = out_ready_i & active;
   assign out_data_o  = r_data_i;
   assign out_last_o  = active & (beat_q == fifo_q[rd_ptr_q]);
   assign busy_o      = ar_valid_o | active;
   assign err_o       = err_q;

   assign cmd_hs = cmd_valid_i & cmd_ready_o;
   assign r_hs   = r_valid_i & r_ready_o;
   assign push   = cmd_hs;
   assign pop    = r_hs & out_last_o;

   always_comb begin
      ar_addr_d = cmd_hs ? {cmd_addr_i[31:3], 3'b000} : ar_addr_q;
      ar_len_d  = cmd_hs ? cmd_len_i : ar_len_q;
      count_d   = count_q + CW'(push) - CW'(pop);
      beat_d    = r_hs ? (out_last_o ? 8'd0 : beat_q + 8'd1) : beat_q;
      err_d     = (err_clr_i ? 2'b00 : err_q) | {r_hs & (r_last_i != out_last_o), r_hs & (r_resp_i != 2'b00)};
   end

   always_ff @(posedge clock_i or negedge reset_ni)
      if (!reset_ni) begin
         ar_addr_q <= '0;
         ar_len_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         beat_q    <= '0;
         err_q     <= '0;
      end else begin
         ar_addr_q <= ar_addr_d;
         ar_len_q  <= ar_len_d;
         wr_ptr_q  <= wr_ptr_q + AW'(push);
         rd_ptr_q  <= rd_ptr_q + AW'(pop);
         count_q   <= count_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
      end

   always_ff @(posedge clock_i)
      if (push) fifo_q[wr_ptr_q] <= cmd_len_i;
endmodule
